// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: DIFF = A - B - BIN over WIDTH bits, LSB first, one bit per clock.
// A single full-subtractor cell is reused every cycle; the borrow flop chains the bits.

module fs_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);
  assign d_o    = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
endmodule

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             bout_o
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_a_q, shift_a_d;
  logic [WIDTH-1:0] shift_b_q, shift_b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             done_q, done_d;

  logic bit_d;
  logic bit_bout;

  fs_cell u_cell (
    .a_i    (shift_a_q[0]),
    .b_i    (shift_b_q[0]),
    .bin_i  (borrow_q),
    .d_o    (bit_d),
    .bout_o (bit_bout)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_a_q <= '0;
      shift_b_q <= '0;
      res_q     <= '0;
      borrow_q  <= 1'b0;
      diff_q    <= '0;
      bout_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_a_q <= shift_a_d;
      shift_b_q <= shift_b_d;
      res_q     <= res_d;
      borrow_q  <= borrow_d;
      diff_q    <= diff_d;
      bout_q    <= bout_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_a_d = shift_a_q;
    shift_b_d = shift_b_q;
    res_d     = res_q;
    borrow_d  = borrow_q;
    diff_d    = diff_q;
    bout_d    = bout_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          shift_a_d = a_i;
          shift_b_d = b_i;
          borrow_d  = bin_i;
          cnt_d     = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        shift_a_d        = shift_a_q >> 1;
        shift_b_d        = shift_b_q >> 1;
        res_d            = res_q >> 1;
        res_d[WIDTH-1]   = bit_d;
        borrow_d         = bit_bout;
        cnt_d            = cnt_q + CW'(1);
        // Publish only the complete word so DIFF never shows partial bits.
        if (cnt_q == LAST) begin
          diff_d  = res_d;
          bout_d  = bit_bout;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q == RUN);
  assign done_o = done_q;
  assign diff_o = diff_q;
  assign bout_o = bout_q;
endmodule
